// File: rtl/ising_ctrl_pkg.sv
// Shared types and widths for the Ising run controller and its phase buffer.
package ising_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CORE_RST = 3'd1,
        RUN      = 3'd2,
        SWEEP    = 3'd3,
        DONE     = 3'd4
    } state_e;

    // Index width for an N-entry table; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ising_phase_buf.sv
// N-entry phase capture buffer: one synchronous write port, one registered read port.
module ising_phase_buf
    import ising_ctrl_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = idx_width(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] mem_d [N];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mem_d[i] = (wr_en && (wr_idx == IDX_W'(i))) ? wr_data : mem_q[i];
        end
    end

    // Reads sample mem_q, so a same-cycle write to the same entry is not visible yet.
    always_comb begin
        rd_data_d = '0;
        if (rd_addr < ADDR_W'(N)) begin
            rd_data_d = mem_q[rd_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ising_run_ctrl.sv
// Run sequencer for the Ising core: reset, timed run, then a latency-aware
// sweep that captures every spin's phase into a host-readable buffer.
module ising_run_ctrl
    import ising_ctrl_pkg::*;
#(
    parameter int N          = 3,
    parameter int RST_CYCLES = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    input  logic              abort,
    input  logic [31:0]       run_cycles,
    output logic              ising_rstn,
    output logic              start,
    output logic              sweep_active,
    output logic [ADDR_W-1:0] sweep_addr,
    input  logic [DATA_W-1:0] phase,
    output logic              busy,
    output logic              done,
    output logic [31:0]       run_count,
    input  logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data
);

    localparam int IDX_W = idx_width(N);

    logic [1:0]       rst_sync_q;
    logic             rst_n_int;
    state_e           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      run_len_q, run_len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      run_count_q, run_count_d;
    logic             buf_we;
    logic             is_busy;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_q[1];

    assign is_busy = (state_q == CORE_RST) || (state_q == RUN) || (state_q == SWEEP);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_len_d   = run_len_q;
        idx_d       = idx_q;
        run_count_d = run_count_q;
        buf_we      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (go) begin
                    state_d   = CORE_RST;
                    cnt_d     = '0;
                    run_len_d = (run_cycles == 32'd0) ? 32'd1 : run_cycles;
                end
            end
            CORE_RST: begin
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RUN: begin
                if (cnt_q == run_len_q - 32'd1) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            SWEEP: begin
                // cnt_q counts cycles since sweep_addr last changed.
                if (cnt_q == 32'(RD_LAT)) begin
                    buf_we = 1'b1;
                    cnt_d  = '0;
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d     = DONE;
                        run_count_d = run_count_q + 32'd1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && is_busy) begin
            state_d = IDLE;
            buf_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_len_q   <= 32'd1;
            idx_q       <= '0;
            run_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_len_q   <= run_len_d;
            idx_q       <= idx_d;
            run_count_q <= run_count_d;
        end
    end

    ising_phase_buf #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n_int),
        .wr_en   (buf_we),
        .wr_idx  (idx_q),
        .wr_data (phase),
        .rd_addr (buf_addr),
        .rd_data (buf_data)
    );

    assign ising_rstn   = (state_q == RUN) || (state_q == SWEEP);
    assign start        = ising_rstn;
    assign sweep_active = (state_q == SWEEP);
    assign sweep_addr   = sweep_active ? {{(ADDR_W - IDX_W){1'b0}}, idx_q} : '0;
    assign busy         = is_busy;
    assign done         = (state_q == DONE);
    assign run_count    = run_count_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl with a delayed-phase model of the Ising core read path.
module tb_ising_run_ctrl;

    logic        clk = 1'b0;
    logic        rstn, go, abort;
    logic [31:0] run_cycles, phase, buf_addr;
    logic        ising_rstn, start, sweep_active, busy, done;
    logic [31:0] sweep_addr, run_count, buf_data;

    logic [31:0] phase_base = 32'hA0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rc;
        logic [31:0] base;
        int          go1;
        int          go2;
        int          exp_rst;
        int          exp_start;
        logic [31:0] exp_count;
    } run_vec_t;

    run_vec_t vecs [4];

    always #5 clk = ~clk;

    // Core model: phase reflects sweep_addr two cycles later.
    always @(posedge clk) begin
        d1 <= sweep_addr;
        d2 <= d1;
    end
    assign phase = phase_base + d2;

    ising_run_ctrl #(
        .N          (3),
        .RST_CYCLES (4),
        .RD_LAT     (2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .go           (go),
        .abort        (abort),
        .run_cycles   (run_cycles),
        .ising_rstn   (ising_rstn),
        .start        (start),
        .sweep_active (sweep_active),
        .sweep_addr   (sweep_addr),
        .phase        (phase),
        .busy         (busy),
        .done         (done),
        .run_count    (run_count),
        .buf_addr     (buf_addr),
        .buf_data     (buf_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_buf(input logic [31:0] a, input logic [31:0] exp, input string name);
        buf_addr = a;
        tick();
        chk(name, buf_data, exp);
    endtask

    task automatic do_run(input logic [31:0] rc, input int go1, input int go2,
                          output int rst_low, output int start_hi);
        int it;
        rst_low    = 0;
        start_hi   = 0;
        run_cycles = rc;
        go         = 1'b1;
        tick();
        go = 1'b0;
        chk("busy_after_go", {31'b0, busy}, 32'd1);
        chk("done_cleared", {31'b0, done}, 32'd0);
        it = 1;
        while (done !== 1'b1 && it < 300) begin
            if (busy && !ising_rstn) rst_low++;
            if (start) start_hi++;
            go = (it == go1) || (it == go2);
            tick();
            it++;
        end
        go = 1'b0;
        chk("run_reaches_done", {31'b0, done}, 32'd1);
    endtask

    task automatic wait_sweep_addr(input logic [31:0] a, input string name);
        int n;
        n = 0;
        while (!(sweep_active === 1'b1 && sweep_addr == a) && n < 200) begin
            tick();
            n++;
        end
        chk(name, {31'b0, sweep_active}, 32'd1);
    endtask

    initial begin
        int rl, sh;
        rstn       = 1'b0;
        go         = 1'b0;
        abort      = 1'b0;
        run_cycles = '0;
        buf_addr   = '0;

        vecs[0] = '{32'd10, 32'hA0, -1, -1, 4, 19, 32'd1};
        vecs[1] = '{32'd0,  32'hC0, -1, -1, 4, 10, 32'd2};
        vecs[2] = '{32'd10, 32'h90,  8, 18, 4, 19, 32'd3};
        vecs[3] = '{32'd1,  32'hA0, -1, -1, 4, 10, 32'd4};

        tick();
        tick();
        chk("rst_ising_rstn", {31'b0, ising_rstn}, 32'd0);
        chk("rst_start", {31'b0, start}, 32'd0);
        chk("rst_sweep_active", {31'b0, sweep_active}, 32'd0);
        chk("rst_sweep_addr", sweep_addr, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_run_count", run_count, 32'd0);
        chk("rst_buf_data", buf_data, 32'd0);
        rstn = 1'b1;
        repeat (4) tick();

        // Full runs: reset length, start length, capture contents, run counter.
        for (int i = 0; i < 4; i++) begin
            phase_base = vecs[i].base;
            do_run(vecs[i].rc, vecs[i].go1, vecs[i].go2, rl, sh);
            chk($sformatf("v%0d_rst_cycles", i), 32'(rl), 32'(vecs[i].exp_rst));
            chk($sformatf("v%0d_start_cycles", i), 32'(sh), 32'(vecs[i].exp_start));
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd0);
            chk($sformatf("v%0d_run_count", i), run_count, vecs[i].exp_count);
            for (int j = 0; j < 3; j++) begin
                read_buf(32'(j), vecs[i].base + 32'(j), $sformatf("v%0d_buf%0d", i, j));
            end
            read_buf(32'd3, 32'd0, $sformatf("v%0d_buf_oor", i));
            chk($sformatf("v%0d_done_sticky", i), {31'b0, done}, 32'd1);
        end

        // Abort during the second sweep spin.
        phase_base = 32'hB0;
        run_cycles = 32'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("ab_done_cleared", {31'b0, done}, 32'd0);
        wait_sweep_addr(32'd1, "ab_reach_spin1");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", {31'b0, busy}, 32'd0);
        chk("ab_ising_rstn", {31'b0, ising_rstn}, 32'd0);
        chk("ab_start", {31'b0, start}, 32'd0);
        chk("ab_sweep_active", {31'b0, sweep_active}, 32'd0);
        chk("ab_done", {31'b0, done}, 32'd0);
        chk("ab_run_count", run_count, 32'd4);
        tick();
        chk("ab_stays_idle", {31'b0, busy}, 32'd0);
        read_buf(32'd0, 32'hB0, "ab_buf0");
        read_buf(32'd1, 32'hA1, "ab_buf1");
        read_buf(32'd2, 32'hA2, "ab_buf2");

        // go and abort together in IDLE; out-of-range read.
        go       = 1'b1;
        abort    = 1'b1;
        buf_addr = 32'd5;
        tick();
        go    = 1'b0;
        abort = 1'b0;
        chk("ga_busy", {31'b0, busy}, 32'd0);
        chk("ga_buf_oor", buf_data, 32'd0);
        repeat (3) tick();
        chk("ga_still_idle", {31'b0, busy}, 32'd0);
        chk("ga_ising_rstn", {31'b0, ising_rstn}, 32'd0);

        // Asynchronous reset in the middle of a sweep.
        phase_base = 32'hE0;
        buf_addr   = 32'd0;
        run_cycles = 32'd2;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_sweep_addr(32'd2, "mr_reach_spin2");
        chk("mr_pre_buf0", buf_data, 32'hE0);
        #1 rstn = 1'b0;
        #1;
        chk("mr_ising_rstn", {31'b0, ising_rstn}, 32'd0);
        chk("mr_start", {31'b0, start}, 32'd0);
        chk("mr_sweep_active", {31'b0, sweep_active}, 32'd0);
        chk("mr_sweep_addr", sweep_addr, 32'd0);
        chk("mr_busy", {31'b0, busy}, 32'd0);
        chk("mr_run_count", run_count, 32'd0);
        chk("mr_buf_data", buf_data, 32'd0);
        tick();
        rstn = 1'b1;
        repeat (4) tick();
        read_buf(32'd1, 32'd0, "mr_buf1_cleared");
        read_buf(32'd0, 32'd0, "mr_buf0_cleared");

        phase_base = 32'hA0;
        do_run(32'd3, -1, -1, rl, sh);
        chk("post_rst_cycles", 32'(rl), 32'd4);
        chk("post_start_cycles", 32'(sh), 32'd12);
        chk("post_run_count", run_count, 32'd1);
        for (int j = 0; j < 3; j++) begin
            read_buf(32'(j), 32'hA0 + 32'(j), $sformatf("post_buf%0d", j));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
